// File: rtl/sdf_bitrev_reorder_pkg.sv
// Shared SDF/NTT defaults and the address bit-reversal helper used by the reorder buffer.
package sdf_bitrev_reorder_pkg;

    localparam int DEF_DATA_WIDTH = 64;
    localparam int DEF_N_POINTS   = 64;
    localparam int DEF_LOG2N      = 6;

    // Reverses the low nbits of v; bits at and above nbits come back as zero.
    function automatic logic [31:0] bitrev(input logic [31:0] v, input int nbits);
        logic [31:0] r;
        int          j;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < nbits) begin
                j = nbits - 1 - i;
                r[i[4:0]] = v[j[4:0]];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/pingpong_ram.sv
// Two-bank sample store: one synchronous write port, one asynchronous read port.
// Contents are never reset; the bank bit selects the upper half of the array.
module pingpong_ram #(
    parameter int data_width = 64,
    parameter int log2n      = 6
) (
    input  logic                  clk,
    input  logic                  wr_en_i,
    input  logic                  wr_bank_i,
    input  logic [log2n-1:0]      wr_addr_i,
    input  logic [data_width-1:0] wr_data_i,
    input  logic                  rd_bank_i,
    input  logic [log2n-1:0]      rd_addr_i,
    output logic [data_width-1:0] rd_data_o
);

    logic [data_width-1:0] mem_q [2**(log2n+1)];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[{wr_bank_i, wr_addr_i}] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[{rd_bank_i, rd_addr_i}];

endmodule

// File: rtl/sdf_bitrev_reorder.sv
// Bit-reversed to natural order reorder buffer; burst starts one cycle after the frame's last write, no backpressure.
// Optional out_sof/out_eof frame markers when SDF_REORDER_MARKERS_EN is defined.
module sdf_bitrev_reorder
    import sdf_bitrev_reorder_pkg::*;
#(
    parameter int data_width = DEF_DATA_WIDTH,
    parameter int n_points   = DEF_N_POINTS,
    parameter int log2n      = DEF_LOG2N
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [data_width-1:0] in_data,
    input  logic                  in_sof,
    output logic                  out_valid,
    output logic [data_width-1:0] out_data
`ifdef SDF_REORDER_MARKERS_EN
    ,
    output logic                  out_sof,
    output logic                  out_eof
`endif
);

    localparam logic [log2n-1:0] LAST = log2n'(n_points - 1);
    localparam logic [log2n-1:0] ONE  = log2n'(1);

    logic [log2n-1:0]      wr_cnt_q, wr_cnt_d, wr_addr;
    logic [log2n-1:0]      rd_cnt_q, rd_cnt_d, rd_addr;
    logic                  wr_bank_q, wr_bank_d;
    logic                  burst_q, burst_d;
    logic                  frame_done;
    logic                  out_valid_q;
    logic [data_width-1:0] out_data_q;
    logic [data_width-1:0] rd_data;

    always_comb begin
        // A start-of-frame always lands at address 0, which also drops any partial frame.
        wr_addr    = in_sof ? '0 : wr_cnt_q;
        frame_done = in_valid && (wr_addr == LAST);
        wr_cnt_d   = wr_cnt_q;
        wr_bank_d  = wr_bank_q;
        if (in_valid) begin
            wr_cnt_d = wr_addr + ONE;
            if (frame_done) begin
                wr_bank_d = ~wr_bank_q;
            end
        end

        // A completed frame restarts the burst even on the previous burst's final cycle.
        rd_cnt_d = rd_cnt_q;
        burst_d  = burst_q;
        if (frame_done) begin
            burst_d  = 1'b1;
            rd_cnt_d = '0;
        end else if (burst_q) begin
            rd_cnt_d = rd_cnt_q + ONE;
            if (rd_cnt_q == LAST) begin
                burst_d = 1'b0;
            end
        end

        rd_addr = log2n'(bitrev(32'(rd_cnt_q), log2n));
    end

    pingpong_ram #(
        .data_width(data_width),
        .log2n     (log2n)
    ) u_ram (
        .clk       (clk),
        .wr_en_i   (in_valid),
        .wr_bank_i (wr_bank_q),
        .wr_addr_i (wr_addr),
        .wr_data_i (in_data),
        .rd_bank_i (~wr_bank_q),
        .rd_addr_i (rd_addr),
        .rd_data_o (rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            wr_bank_q   <= 1'b0;
            burst_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            wr_bank_q   <= wr_bank_d;
            burst_q     <= burst_d;
            out_valid_q <= burst_q;
            if (burst_q) begin
                out_data_q <= rd_data;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

`ifdef SDF_REORDER_MARKERS_EN
    logic out_sof_q, out_eof_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_sof_q <= 1'b0;
            out_eof_q <= 1'b0;
        end else begin
            out_sof_q <= burst_q && (rd_cnt_q == '0);
            out_eof_q <= burst_q && (rd_cnt_q == LAST);
        end
    end

    assign out_sof = out_sof_q;
    assign out_eof = out_eof_q;
`endif

endmodule

// File: tb/tb_sdf_bitrev_reorder.sv
// Directed bench for the bit-reverse reorder buffer with hand-derived natural-order expectations.
module tb_sdf_bitrev_reorder;

    localparam int DW = 64;
    localparam int NP = 64;
    localparam int LG = 6;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_sof   = 1'b0;
    logic [DW-1:0] in_data  = '0;
    logic          out_valid;
    logic [DW-1:0] out_data;
`ifdef SDF_REORDER_MARKERS_EN
    logic          out_sof;
    logic          out_eof;
`endif

    int     n_cmp = 0;
    int     n_err = 0;
    longint cyc   = 0;

    logic [DW-1:0] obs_q [$];
    longint        cyc_q [$];
`ifdef SDF_REORDER_MARKERS_EN
    logic          sof_q [$];
    logic          eof_q [$];
`endif

    sdf_bitrev_reorder #(
        .data_width(DW),
        .n_points  (NP),
        .log2n     (LG)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_sof   (in_sof),
        .out_valid(out_valid),
        .out_data (out_data)
`ifdef SDF_REORDER_MARKERS_EN
        ,
        .out_sof  (out_sof),
        .out_eof  (out_eof)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            obs_q.push_back(out_data);
            cyc_q.push_back(cyc);
`ifdef SDF_REORDER_MARKERS_EN
            sof_q.push_back(out_sof);
            eof_q.push_back(out_eof);
`endif
        end
    end

    function automatic logic [LG-1:0] br(input logic [LG-1:0] v);
        return {<<{v}};
    endfunction

    task automatic clear_obs();
        obs_q.delete();
        cyc_q.delete();
`ifdef SDF_REORDER_MARKERS_EN
        sof_q.delete();
        eof_q.delete();
`endif
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_sample(input logic sof, input logic [DW-1:0] d);
        in_valid = 1'b1;
        in_sof   = sof;
        in_data  = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    // Sample i carries br(i)+base, so natural output k must read base+k.
    task automatic send_frame(input logic [DW-1:0] base, input logic sof0, input logic gaps,
                              output longint last_edge);
        for (int i = 0; i < NP; i++) begin
            send_sample(sof0 && (i == 0), DW'(br(LG'(i))) + base);
            if (gaps && i < NP - 1) idle(1);
        end
        last_edge = cyc;
    endtask

    task automatic test_reset();
        in_valid = 1'b1;
        in_data  = 64'hdead;
        idle(2);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_valid: got %b want 0", out_valid);
        end
        n_cmp++;
        if (out_data !== '0) begin
            n_err++;
            $display("FAIL reset_data: got %0h want 0", out_data);
        end
`ifdef SDF_REORDER_MARKERS_EN
        n_cmp++;
        if (out_sof !== 1'b0 || out_eof !== 1'b0) begin
            n_err++;
            $display("FAIL reset_markers: got %b%b want 00", out_sof, out_eof);
        end
`endif
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(3);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL post_reset_idle: got %b want 0", out_valid);
        end
    endtask

    task automatic test_single_frame();
        longint e;
        clear_obs();
        send_frame(64'd100, 1'b1, 1'b0, e);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL single_early_valid: got %b want 0", out_valid);
        end
        idle(NP + 4);
        n_cmp++;
        if (obs_q.size() !== NP) begin
            n_err++;
            $display("FAIL single_count: got %0d want %0d", obs_q.size(), NP);
        end else begin
            for (int k = 0; k < NP; k++) begin
                n_cmp++;
                if (obs_q[k] !== 64'(100 + k) || cyc_q[k] !== e + 1 + k) begin
                    n_err++;
                    $display("FAIL single_out[%0d]: got %0d @%0d want %0d @%0d",
                             k, obs_q[k], cyc_q[k], 100 + k, e + 1 + k);
                end
`ifdef SDF_REORDER_MARKERS_EN
                n_cmp++;
                if (sof_q[k] !== (k == 0) || eof_q[k] !== (k == NP - 1)) begin
                    n_err++;
                    $display("FAIL single_markers[%0d]: got sof=%b eof=%b want sof=%b eof=%b",
                             k, sof_q[k], eof_q[k], k == 0, k == NP - 1);
                end
`endif
            end
        end
        n_cmp++;
        if (out_valid !== 1'b0 || out_data !== 64'd163) begin
            n_err++;
            $display("FAIL single_hold: got valid=%b data=%0d want valid=0 data=163",
                     out_valid, out_data);
        end
    endtask

    task automatic test_back_to_back();
        longint e1, e2, e3;
        clear_obs();
        send_frame(64'd100, 1'b0, 1'b0, e1);
        send_frame(64'd1100, 1'b0, 1'b0, e2);
        send_frame(64'd2100, 1'b0, 1'b0, e3);
        idle(NP + 4);
        n_cmp++;
        if (obs_q.size() !== 3 * NP) begin
            n_err++;
            $display("FAIL b2b_count: got %0d want %0d", obs_q.size(), 3 * NP);
        end else begin
            for (int k = 0; k < 3 * NP; k++) begin
                n_cmp++;
                if (obs_q[k] !== 64'(100 + 1000 * (k / NP) + (k % NP)) || cyc_q[k] !== e1 + 1 + k) begin
                    n_err++;
                    $display("FAIL b2b_out[%0d]: got %0d @%0d want %0d @%0d", k, obs_q[k], cyc_q[k],
                             100 + 1000 * (k / NP) + (k % NP), e1 + 1 + k);
                end
            end
        end
    endtask

    task automatic test_gaps();
        longint e;
        clear_obs();
        send_frame(64'd200, 1'b0, 1'b1, e);
        idle(NP + 4);
        n_cmp++;
        if (obs_q.size() !== NP) begin
            n_err++;
            $display("FAIL gaps_count: got %0d want %0d", obs_q.size(), NP);
        end else begin
            for (int k = 0; k < NP; k++) begin
                n_cmp++;
                if (obs_q[k] !== 64'(200 + k) || cyc_q[k] !== e + 1 + k) begin
                    n_err++;
                    $display("FAIL gaps_out[%0d]: got %0d @%0d want %0d @%0d",
                             k, obs_q[k], cyc_q[k], 200 + k, e + 1 + k);
                end
            end
        end
    endtask

    // Frame A's burst runs while 20 stray samples and then a restarted frame B arrive.
    task automatic test_sof_discard();
        longint ea, eb;
        clear_obs();
        send_frame(64'd400, 1'b0, 1'b0, ea);
        for (int i = 0; i < 20; i++) send_sample(1'b0, 64'(5000 + i));
        send_frame(64'd300, 1'b1, 1'b0, eb);
        idle(NP + 4);
        n_cmp++;
        if (obs_q.size() !== 2 * NP) begin
            n_err++;
            $display("FAIL sof_count: got %0d want %0d", obs_q.size(), 2 * NP);
        end else begin
            for (int k = 0; k < 2 * NP; k++) begin
                n_cmp++;
                if (k < NP ? (obs_q[k] !== 64'(400 + k) || cyc_q[k] !== ea + 1 + k)
                           : (obs_q[k] !== 64'(300 + k - NP) || cyc_q[k] !== eb + 1 + k - NP)) begin
                    n_err++;
                    $display("FAIL sof_out[%0d]: got %0d @%0d want %0d", k, obs_q[k], cyc_q[k],
                             k < NP ? 400 + k : 300 + k - NP);
                end
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        longint e;
        clear_obs();
        send_frame(64'd500, 1'b0, 1'b0, e);
        for (int i = 0; i < 10; i++) send_sample(1'b0, 64'(9000 + i));
        idle(21);
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== 64'd530) begin
            n_err++;
            $display("FAIL rst_pre_idx30: got valid=%b data=%0d want valid=1 data=530",
                     out_valid, out_data);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || out_data !== '0) begin
            n_err++;
            $display("FAIL rst_async_clear: got valid=%b data=%0d want valid=0 data=0",
                     out_valid, out_data);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        clear_obs();
        send_frame(64'd600, 1'b0, 1'b0, e);
        idle(NP + 4);
        n_cmp++;
        if (obs_q.size() !== NP) begin
            n_err++;
            $display("FAIL rst_fresh_count: got %0d want %0d", obs_q.size(), NP);
        end else begin
            for (int k = 0; k < NP; k++) begin
                n_cmp++;
                if (obs_q[k] !== 64'(600 + k) || cyc_q[k] !== e + 1 + k) begin
                    n_err++;
                    $display("FAIL rst_fresh_out[%0d]: got %0d @%0d want %0d @%0d",
                             k, obs_q[k], cyc_q[k], 600 + k, e + 1 + k);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_gaps();
        test_sof_discard();
        test_reset_mid_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
